// File: rtl/smd_pad_reader.sv
// Reader for a Sega-style 3/6-button pad: drives select, samples p in phases, decodes buttons.
// Define SMD_PAD_READER_SIXBTN_EN to build the 8-phase six-button sequence.
module smd_pad_reader #(
    parameter int CLK_FREQ     = 20000000,
    parameter int PHASE_CYCLES = 200,
    parameter int POLL_CYCLES  = 333333
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [5:0]  p,
    output logic        sel,
    output logic [11:0] btn,
    output logic        present,
    output logic        six_btn,
    output logic        valid
);

    localparam int PCW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int POW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

`ifdef SMD_PAD_READER_SIXBTN_EN
    localparam logic [2:0] LAST_PHASE = 3'd7;
`else
    localparam logic [2:0] LAST_PHASE = 3'd1;
`endif

    if (PHASE_CYCLES < 4 || POLL_CYCLES <= 8 * PHASE_CYCLES || CLK_FREQ <= 0) begin : g_param_check
        $error("smd_pad_reader: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [2:0]       phase;
    logic [PCW-1:0]   ph_cnt;
    logic [POW-1:0]   poll_cnt;
    logic             poll_wrap;
    logic             ph_end;
    logic [5:0]       p_m;
    logic [5:0]       p_s;
    logic [5:0]       s0;
    logic [1:0]       s1;
    logic             pres_s;
    logic [7:0]       btn_lo;

`ifdef SMD_PAD_READER_SIXBTN_EN
    logic             cand;
    logic [3:0]       s4;
    logic             six_s;
    logic [3:0]       btn_hi;
    logic             six_q;

    assign btn     = {btn_hi, btn_lo};
    assign six_btn = six_q;
`else
    assign btn     = {4'b0000, btn_lo};
    assign six_btn = 1'b0;
`endif

    assign poll_wrap = (poll_cnt == POW'(POLL_CYCLES - 1));
    assign ph_end    = (ph_cnt == PCW'(PHASE_CYCLES - 1));

    // p is asynchronous to clk; idle (released) level is all ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_m <= '1;
            p_s <= '1;
        end else begin
            p_m <= p;
            p_s <= p_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt <= '0;
        end else if (poll_wrap) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= '0;
            ph_cnt  <= '0;
            sel     <= 1'b1;
            valid   <= 1'b0;
            present <= 1'b0;
            btn_lo  <= '0;
            s0      <= '1;
            s1      <= '1;
            pres_s  <= 1'b0;
`ifdef SMD_PAD_READER_SIXBTN_EN
            cand    <= 1'b0;
            s4      <= '1;
            six_s   <= 1'b0;
            btn_hi  <= '0;
            six_q   <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (poll_wrap && en) begin
                        state  <= RUN;
                        phase  <= '0;
                        ph_cnt <= '0;
                        sel    <= 1'b1;
                    end
                end
                RUN: begin
                    if (ph_end) begin
                        ph_cnt <= '0;
                        case (phase)
                            3'd0: s0 <= p_s;
                            3'd1: begin
                                s1     <= p_s[1:0];
                                pres_s <= (p_s[3:2] == 2'b00);
                            end
`ifdef SMD_PAD_READER_SIXBTN_EN
                            3'd3: cand  <= (p_s[5:2] == 4'b0000);
                            3'd4: s4    <= p_s[5:2];
                            3'd5: six_s <= cand && (p_s[5:2] == 4'b1111);
`endif
                            default: ;
                        endcase
                        if (phase == LAST_PHASE) begin
                            state <= DONE;
                            sel   <= 1'b1;
                        end else begin
                            // next phase is odd (sel low) when the current one is even
                            phase <= phase + 3'd1;
                            sel   <= phase[0];
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    valid   <= 1'b1;
                    present <= pres_s;
                    // {st, c, b, a, rg, lf, dw, up}, inverted from active-low levels
                    btn_lo  <= pres_s ? ~{s1[0], s0[0], s0[1], s1[1],
                                          s0[2], s0[3], s0[4], s0[5]} : 8'h00;
`ifdef SMD_PAD_READER_SIXBTN_EN
                    six_q   <= pres_s && six_s;
                    // {md, z, y, x} from the phase 4 sample {z, y, x, md}
                    btn_hi  <= (pres_s && six_s) ? ~{s4[0], s4[3], s4[2], s4[1]} : 4'h0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smd_pad_reader.sv
// Randomized bench for smd_pad_reader with a behavioural pad model and expected-value model.
// Honours SMD_PAD_READER_SIXBTN_EN to match the build under test.
module tb_smd_pad_reader;

    localparam int PH   = 200;
    localparam int POLL = 3000;
`ifdef SMD_PAD_READER_SIXBTN_EN
    localparam bit SIX = 1'b1;
    localparam int NPH = 8;
`else
    localparam bit SIX = 1'b0;
    localparam int NPH = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [5:0]  p;
    logic        sel;
    logic [11:0] btn;
    logic        present;
    logic        six_btn;
    logic        valid;

    int          checks = 0;
    int          errors = 0;

    // pad stimulus: type 0 = none, 1 = three-button, 2 = six-button
    int          pad_t = 0;
    logic [11:0] pad_b = '0;

    // monitor state, updated on the falling edge
    logic        sel_q = 1'b1;
    int          k = 0;
    int          hi_cnt = 0;
    int          low_w = 0;
    int          low_total = 0;
    int          bad_w_total = 0;
    int          valid_total = 0;

    smd_pad_reader #(
        .CLK_FREQ    (20000000),
        .PHASE_CYCLES(PH),
        .POLL_CYCLES (POLL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .p      (p),
        .sel    (sel),
        .btn    (btn),
        .present(present),
        .six_btn(six_btn),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    // pad line levels for select-edge count kk; b is the pressed set in btn bit order
    function automatic logic [5:0] pad_p(input int t, input logic [11:0] b, input int kk);
        logic [11:0] r;
        r = ~b;
        if (t == 0) return 6'h3F;
        if (kk % 2 == 0) begin
            if (t == 2 && kk == 4) return {r[10], r[9], r[8], r[11], r[5], r[6]};
            return {r[0], r[1], r[2], r[3], r[5], r[6]};
        end
        if (t == 2 && kk == 3) return {4'b0000, r[4], r[7]};
        if (t == 2 && kk == 5) return {4'b1111, r[4], r[7]};
        return {r[0], r[1], 2'b00, r[4], r[7]};
    endfunction

    function automatic logic [11:0] exp_btn(input int t, input logic [11:0] b);
        if (t == 0) return 12'h000;
        if (t == 2 && SIX) return b;
        return b & 12'h0FF;
    endfunction

    always_comb p = pad_p(pad_t, pad_b, k);

    // the pad counts select edges and forgets them after a long high idle
    always @(negedge clk) begin
        sel_q <= sel;
        if (valid) valid_total <= valid_total + 1;
        if (rst) begin
            k      <= 0;
            hi_cnt <= 0;
            low_w  <= 0;
        end else begin
            if (sel != sel_q) k <= k + 1;
            else if (sel && hi_cnt == 2 * PH) k <= 0;
            hi_cnt <= (sel && sel_q) ? hi_cnt + 1 : 0;
            if (!sel) low_w <= sel_q ? 1 : low_w + 1;
            if (!sel && sel_q) low_total <= low_total + 1;
            if (sel && !sel_q && low_w != PH) bad_w_total <= bad_w_total + 1;
        end
    end

    task automatic wait_valid(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (valid) ok = 1'b1;
        end
    endtask

    task automatic run_poll(input string name, input int t, input logic [11:0] b);
        int n;
        bit ok;
        int lo0, bw0, v0;
        pad_t = t;
        pad_b = b;
        lo0 = low_total;
        bw0 = bad_w_total;
        v0  = valid_total;
        wait_valid(2 * POLL, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: no valid in %0d cycles, required one", name, n);
        end
        checks++;
        if (btn !== exp_btn(t, b)) begin
            errors++;
            $display("FAIL %s_btn: got %h, expected %h", name, btn, exp_btn(t, b));
        end
        checks++;
        if (present !== (t != 0)) begin
            errors++;
            $display("FAIL %s_present: got %b, expected %b", name, present, t != 0);
        end
        checks++;
        if (six_btn !== (t == 2 && SIX)) begin
            errors++;
            $display("FAIL %s_six: got %b, expected %b", name, six_btn, t == 2 && SIX);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || valid_total - v0 != 1) begin
            errors++;
            $display("FAIL %s_valid_pulse: got %0d pulses (valid now %b), expected 1", name,
                     valid_total - v0, valid);
        end
        checks++;
        if (low_total - lo0 != NPH / 2 || bad_w_total != bw0) begin
            errors++;
            $display("FAIL %s_sel: got %0d low pulses, %0d bad widths, expected %0d, 0", name,
                     low_total - lo0, bad_w_total - bw0, NPH / 2);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (sel !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_sel_valid: got sel=%b valid=%b, expected 1 0", sel, valid);
        end
        checks++;
        if (btn !== 12'h000 || present !== 1'b0 || six_btn !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got btn=%h present=%b six=%b, expected 000 0 0",
                     btn, present, six_btn);
        end
        rst = 1'b0;
    endtask

    task automatic test_six_pad;
        run_poll("six_up_a_z", 2, 12'h411);
        run_poll("six_x", 2, 12'h100);
    endtask

    task automatic test_three_pad;
        run_poll("three_st", 1, 12'h080);
    endtask

    task automatic test_no_pad;
        run_poll("no_pad", 0, 12'($urandom));
    endtask

    task automatic test_random_hold;
        logic [11:0] held;
        for (int i = 0; i < 4; i++) begin
            int t;
            t = int'($urandom_range(0, 2));
            run_poll("random", t, 12'($urandom));
            held  = btn;
            pad_t = int'($urandom_range(1, 2));
            pad_b = 12'($urandom);
            repeat (500) @(negedge clk);
            checks++;
            if (btn !== held || valid !== 1'b0) begin
                errors++;
                $display("FAIL hold: got btn=%h valid=%b, expected %h 0", btn, valid, held);
            end
            pad_t = t;
        end
    endtask

    task automatic test_reset_mid_poll;
        int n;
        bit ok;
        int v0;
        pad_t = 2;
        pad_b = 12'($urandom);
        n = 0;
        while (sel !== 1'b0 && n < 2 * POLL) begin
            @(negedge clk);
            n++;
        end
        repeat (SIX ? 3 * PH + PH / 2 : PH / 2) @(negedge clk);
        v0  = valid_total;
        rst = 1'b1;
        #1;
        checks++;
        if (sel !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_sel: got sel=%b valid=%b, expected 1 0", sel, valid);
        end
        repeat (10) @(negedge clk);
        rst = 1'b0;
        wait_valid(POLL + NPH * PH + 50, n, ok);
        checks++;
        if (!ok || n != POLL + NPH * PH + 1) begin
            errors++;
            $display("FAIL midreset_latency: got %0d cycles (seen %b), expected %0d", n, ok,
                     POLL + NPH * PH + 1);
        end
        @(negedge clk);
        checks++;
        if (valid_total - v0 != 1 || btn !== exp_btn(2, pad_b)) begin
            errors++;
            $display("FAIL midreset_result: got %0d pulses btn=%h, expected 1 %h",
                     valid_total - v0, btn, exp_btn(2, pad_b));
        end
    endtask

    task automatic test_en;
        int n;
        bit ok;
        int lo0, v0;
        pad_t = 1;
        pad_b = 12'($urandom);
        en  = 1'b0;
        lo0 = low_total;
        v0  = valid_total;
        repeat (POLL + 100) @(negedge clk);
        checks++;
        if (low_total != lo0 || valid_total != v0) begin
            errors++;
            $display("FAIL en_off: got %0d low pulses %0d valids, expected 0 0",
                     low_total - lo0, valid_total - v0);
        end
        en = 1'b1;
        n  = 0;
        while (sel !== 1'b0 && n < 2 * POLL) begin
            @(negedge clk);
            n++;
        end
        if (SIX) begin
            while (sel !== 1'b1 && n < 2 * POLL) begin
                @(negedge clk);
                n++;
            end
            repeat (PH / 2) @(negedge clk);
        end
        en = 1'b0;
        wait_valid(NPH * PH + 10, n, ok);
        checks++;
        if (!ok || btn !== exp_btn(1, pad_b)) begin
            errors++;
            $display("FAIL en_drop: got valid=%b btn=%h, expected 1 %h", ok, btn,
                     exp_btn(1, pad_b));
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_six_pad();
        test_three_pad();
        test_no_pad();
        test_random_hold();
        test_reset_mid_poll();
        test_en();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
